// File: rtl/clk_d_monitor.sv
// rtl/clk_d_monitor.sv - divided-clock receiver: edge ticks, half-period measurement, lock/loss
//
// Purpose: brings a slow divided square wave into the clk domain, emits one-cycle
// rise/fall enables, measures each half-period in clk cycles and tracks lock
// against an expected half-period with a +/- tolerance window.
//
// Ports:
//   clk           in   system clock (only clock)
//   rst           in   synchronous active-high reset
//   clk_d_in      in   divided square wave, asynchronous to clk
//   rise_tick     out  one-cycle pulse per synchronized rising edge
//   fall_tick     out  one-cycle pulse per synchronized falling edge
//   half_period   out  last measured edge-to-edge interval, held between updates
//   period_valid  out  one-cycle pulse when half_period updates
//   locked        out  high while LOCKED
//   lost          out  one-cycle pulse on every LOCKED -> MEASURE exit
module clk_d_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 20,
  parameter int EXPECT_HALF = 5000,
  parameter int TOL         = 16,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_d_in,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_WIDTH-1:0] half_period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 lost
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] WIN_LO      = CNT_WIDTH'(EXPECT_HALF - TOL);
  localparam logic [CNT_WIDTH-1:0] WIN_HI      = CNT_WIDTH'(EXPECT_HALF + TOL);
  localparam logic [GOOD_W-1:0]    GOOD_ONE    = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    GOOD_LOCK   = GOOD_W'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0]    IDLE_ONE    = IDLE_W'(1);
  localparam logic [IDLE_W-1:0]    IDLE_LAST   = IDLE_W'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, LOCKED} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [GOOD_W-1:0]      good;
  logic [IDLE_W-1:0]      idle_cnt;

  logic                   sync_out;
  logic                   wave_edge;
  logic [CNT_WIDTH-1:0]   interval;
  logic                   interval_good;
  logic [GOOD_W-1:0]      good_inc;

  assign sync_out  = sync[SYNC_STAGES-1];
  // Edges are ignored in IDLE so the sync chain filling after reset never ticks.
  assign wave_edge = (sync_out != prev) && (state != IDLE);

  // cnt+1 saturated: cycles elapsed since the previous edge, also the next cnt value.
  assign interval      = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  // A saturated interval can hide any real length, so it never counts as good.
  assign interval_good = (interval != CNT_MAX) && (interval >= WIN_LO) && (interval <= WIN_HI);
  assign good_inc      = good + GOOD_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= '0;
      prev         <= 1'b0;
      cnt          <= '0;
      good         <= '0;
      idle_cnt     <= '0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], clk_d_in};
      prev         <= sync_out;
      rise_tick    <= wave_edge && sync_out;
      fall_tick    <= wave_edge && !sync_out;
      period_valid <= 1'b0;
      lost         <= 1'b0;
      cnt          <= wave_edge ? '0 : interval;

      case (state)
        IDLE: begin
          if (idle_cnt == IDLE_LAST) state <= ARMED;
          else idle_cnt <= idle_cnt + IDLE_ONE;
        end
        ARMED: begin
          // First edge only starts the interval count; nothing to report yet.
          if (wave_edge) state <= MEASURE;
        end
        MEASURE: begin
          if (wave_edge) begin
            half_period  <= interval;
            period_valid <= 1'b1;
            if (interval_good) begin
              if (good_inc == GOOD_LOCK) begin
                good   <= '0;
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                good <= good_inc;
              end
            end else begin
              good <= '0;
            end
          end
        end
        LOCKED: begin
          // An edge takes priority over the timeout in the same cycle.
          if (wave_edge) begin
            half_period  <= interval;
            period_valid <= 1'b1;
            if (!interval_good) begin
              state  <= MEASURE;
              locked <= 1'b0;
              lost   <= 1'b1;
              good   <= '0;
            end
          end else if (cnt == WIN_HI) begin
            state  <= MEASURE;
            locked <= 1'b0;
            lost   <= 1'b1;
            good   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_d_monitor.sv
// tb/tb_clk_d_monitor.sv - self-checking bench for clk_d_monitor
module tb_clk_d_monitor;
  localparam int SYNC = 2;
  localparam int CW   = 8;
  localparam int EXP  = 100;
  localparam int TOLV = 8;
  localparam int LC   = 4;
  localparam int D    = SYNC + 1;
  localparam int LO   = EXP - TOLV;
  localparam int HI   = EXP + TOLV;
  localparam int MAXV = (1 << CW) - 1;
  localparam int MAXJ = 32768;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_d_in;
  logic          rise_tick, fall_tick, period_valid, locked, lost;
  logic [CW-1:0] half_period;

  clk_d_monitor #(
    .SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .EXPECT_HALF(EXP), .TOL(TOLV), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .clk_d_in(clk_d_in),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .half_period(half_period),
    .period_valid(period_valid), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: timestamps of input toggles, delayed by the sync latency.
  int   j = 0;
  bit   in_at [MAXJ];
  logic rst_q;
  logic level;
  bit   waiting;
  int   m_good;
  bit   m_locked;
  int   hp;
  int   last_edge;
  int   idle_until;
  logic [CW+4:0] obs, expv;

  task automatic cyc(input logic din, input logic r);
    logic e_r, e_f, e_pv, e_lost;
    int   iv;
    @(negedge clk);
    j++;
    if (j >= MAXJ) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", j, MAXJ);
      $fatal(1);
    end
    e_r = 0; e_f = 0; e_pv = 0; e_lost = 0;
    if (rst_q) begin
      waiting = 1; m_good = 0; m_locked = 0; hp = 0; idle_until = j + D;
    end else if (j > idle_until && in_at[j-D] != in_at[j-D-1]) begin
      e_r = in_at[j-D];
      e_f = !in_at[j-D];
      if (waiting) waiting = 0;
      else begin
        iv = j - last_edge;
        if (iv > MAXV) iv = MAXV;
        hp = iv;
        e_pv = 1;
        if (iv >= LO && iv <= HI && iv != MAXV) begin
          if (!m_locked) begin
            m_good++;
            if (m_good == LC) begin m_locked = 1; m_good = 0; end
          end
        end else begin
          if (m_locked) e_lost = 1;
          m_locked = 0; m_good = 0;
        end
      end
      last_edge = j;
    end else if (m_locked && (j - last_edge) == HI + 1) begin
      m_locked = 0; e_lost = 1; m_good = 0;
    end
    expv = {e_r, e_f, e_pv, m_locked, e_lost, CW'(hp)};
    obs  = {rise_tick, fall_tick, period_valid, locked, lost, half_period};
    clk_d_in = din; rst = r; rst_q = r; in_at[j] = din; level = din;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", obs); end
    end
  endtask

  task automatic test_quiet();
    int seen = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL quiet_cycle j=%0d got=%h exp=%h", j, obs, expv); end
      if (rise_tick || fall_tick || period_valid || locked || lost) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL quiet_activity got=%0d exp=0", seen); end
  endtask

  task automatic test_lock();
    int npv = 0, lock_at = 0;
    bit first = 0;
    for (int h = 0; h < 7; h++) begin
      for (int c = 0; c < EXP; c++) begin
        cyc(c == 0 ? ~level : level, 1'b0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL lock_cycle j=%0d got=%h exp=%h", j, obs, expv); end
        if ((rise_tick || fall_tick) && !first) begin
          first = 1;
          checks++;
          if (period_valid !== 1'b0) begin failures++; $display("FAIL lock_first_edge_pv got=%b exp=0", period_valid); end
        end
        if (period_valid === 1'b1) begin
          npv++;
          checks++;
          if (half_period !== CW'(EXP)) begin failures++; $display("FAIL lock_half_period got=%0d exp=%0d", half_period, EXP); end
        end
        if (locked === 1'b1 && lock_at == 0) lock_at = npv;
      end
    end
    checks++;
    if (lock_at !== LC) begin failures++; $display("FAIL lock_index got=%0d exp=%0d", lock_at, LC); end
  endtask

  task automatic test_tolerance();
    int q [15]      = '{LO-1, LO, HI, LO, HI, HI+1, EXP, EXP, EXP, LO-1, EXP, EXP, EXP, EXP, EXP};
    bit exp_lk [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int h = 0; h < 15; h++) begin
      for (int c = 0; c < q[h]; c++) begin
        cyc(c == 0 ? ~level : level, 1'b0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL tol_cycle j=%0d got=%h exp=%h", j, obs, expv); end
      end
      if (h >= 1) begin
        checks++;
        if (locked !== exp_lk[h-1]) begin
          failures++; $display("FAIL tol_lock_state half=%0d got=%b exp=%b", h - 1, locked, exp_lk[h-1]);
        end
      end
    end
  endtask

  task automatic test_bad_interval();
    int q [11] = '{EXP, EXP, EXP, EXP, EXP, LO-12, EXP, EXP, EXP, EXP, EXP};
    int saw = 0;
    for (int h = 0; h < 11; h++) begin
      for (int c = 0; c < q[h]; c++) begin
        cyc(c == 0 ? ~level : level, 1'b0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL bad_cycle j=%0d got=%h exp=%h", j, obs, expv); end
        if (period_valid === 1'b1 && half_period === CW'(LO-12)) begin
          saw++;
          checks++;
          if (lost !== 1'b1 || locked !== 1'b0) begin
            failures++; $display("FAIL bad_lost got=lost%b/locked%b exp=lost1/locked0", lost, locked);
          end
        end
      end
    end
    checks++;
    if (saw !== 1) begin failures++; $display("FAIL bad_seen got=%0d exp=1", saw); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL bad_relock got=%b exp=1", locked); end
  endtask

  task automatic test_stall();
    int q [9] = '{EXP, EXP, 180, 300, EXP, EXP, EXP, EXP, EXP};
    int tick_j = 0, n_lost = 0, gap = 0;
    bit saw180 = 0, saw_sat = 0;
    for (int h = 0; h < 9; h++) begin
      for (int c = 0; c < q[h]; c++) begin
        cyc(c == 0 ? ~level : level, 1'b0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL stall_cycle j=%0d got=%h exp=%h", j, obs, expv); end
        if (lost === 1'b1) begin n_lost++; gap = j - tick_j; end
        if (rise_tick === 1'b1 || fall_tick === 1'b1) tick_j = j;
        if (period_valid === 1'b1 && half_period === CW'(180)) begin
          saw180 = 1;
          checks++;
          if (locked !== 1'b0) begin failures++; $display("FAIL stall_late_locked got=%b exp=0", locked); end
        end
        if (period_valid === 1'b1 && half_period === CW'(MAXV)) begin
          saw_sat = 1;
          checks++;
          if (locked !== 1'b0 || lost !== 1'b0) begin
            failures++; $display("FAIL stall_saturated got=locked%b/lost%b exp=0/0", locked, lost);
          end
        end
      end
    end
    checks++;
    if (n_lost !== 1) begin failures++; $display("FAIL stall_lost_count got=%0d exp=1", n_lost); end
    checks++;
    if (gap !== HI + 1) begin failures++; $display("FAIL stall_timeout_gap got=%0d exp=%0d", gap, HI + 1); end
    checks++;
    if ({saw180, saw_sat} !== 2'b11) begin failures++; $display("FAIL stall_reports got=%b exp=11", {saw180, saw_sat}); end
  endtask

  task automatic test_reset_mid_lock();
    int since = -1;
    bit done = 0;
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL rstmid_precond got=%b exp=1", locked); end
    for (int h = 0; h < 3; h++) begin
      for (int c = 0; c < EXP; c++) begin
        cyc(c == 0 ? ~level : level, (h == 1 && c == 50));
        if (since >= 0) since++;
        if (h == 1 && c == 50) since = 0;
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL rstmid_cycle j=%0d got=%h exp=%h", j, obs, expv); end
        if (since == 1) begin
          checks++;
          if (obs !== '0) begin failures++; $display("FAIL rstmid_zero got=%h exp=0", obs); end
        end
        if (since >= 2 && since <= D + 1) begin
          checks++;
          if ((rise_tick | fall_tick) !== 1'b0) begin failures++; $display("FAIL rstmid_idle_tick got=1 exp=0"); end
        end
        if (since > D + 1 && !done && (rise_tick === 1'b1 || fall_tick === 1'b1)) begin
          done = 1;
          checks++;
          if (period_valid !== 1'b0) begin failures++; $display("FAIL rstmid_first_pv got=%b exp=0", period_valid); end
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL rstmid_first_edge got=%b exp=1", done); end
  endtask

  task automatic test_random();
    int npv = 0;
    for (int h = 0; h < 40; h++) begin
      int n;
      logic r;
      if ($urandom_range(0, 9) == 0) n = $urandom_range(HI + 1, 300);
      else n = $urandom_range(LO - 4, HI + 4);
      for (int c = 0; c < n; c++) begin
        r = ($urandom_range(0, 1999) == 0);
        cyc(c == 0 ? ~level : level, r);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL random_cycle j=%0d got=%h exp=%h", j, obs, expv); end
        if (period_valid === 1'b1) npv++;
      end
    end
    checks++;
    if (npv == 0) begin failures++; $display("FAIL random_periods got=0 exp=nonzero"); end
  endtask

  initial begin
    rst = 1'b1; rst_q = 1'b1; clk_d_in = 1'b1; level = 1'b1; in_at[0] = 1'b1;
    waiting = 1; m_good = 0; m_locked = 0; hp = 0; last_edge = 0; idle_until = 0;
    test_reset();
    test_quiet();
    test_lock();
    test_tolerance();
    test_bad_interval();
    test_stall();
    test_reset_mid_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
